// File: rtl/run_ctrl_monitor.sv
// run_ctrl_monitor: sequences SoC core reset, counts run cycles, and watches
// per-hart halt levels (ANY/ALL policy) plus an optional cycle-limit timeout.
// Captures the cycle and PC at completion for host/bench reporting.
module run_ctrl_monitor #(
   parameter int NUM_HARTS  = 1,
   parameter int CNT_W      = 32,
   parameter int PC_W       = 48,
   parameter int RESET_HOLD = 4,
   parameter int HALT_MODE  = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [CNT_W-1:0]          max_cycles,
   input  logic [NUM_HARTS-1:0]      hart_halt,
   input  logic [NUM_HARTS*PC_W-1:0] hart_pc,
   output logic                      core_resetn,
   output logic                      running,
   output logic                      done,
   output logic                      timeout,
   output logic [CNT_W-1:0]          cycle_count,
   output logic [NUM_HARTS-1:0]      halt_mask,
   output logic [CNT_W-1:0]          halt_cycle,
   output logic [PC_W-1:0]           halt_pc,
   output logic [1:0]                state
);

   // A hold of zero would skip the reset pulse entirely; keep at least one cycle.
   localparam int          HOLD      = (RESET_HOLD < 1) ? 1 : RESET_HOLD;
   localparam logic [31:0] HOLD_LAST = 32'(HOLD - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RESET = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t               state_q;
   state_t               state_nxt;
   logic [CNT_W-1:0]     limit_q;
   logic [31:0]          hold_cnt;
   logic [NUM_HARTS-1:0] halt_m;
   logic                 start_acc;
   logic                 complete;
   logic                 limit_hit;

   assign state = state_q;

   // Saturating increment so a very long unlimited run never wraps to zero.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // PC of the lowest-index hart whose halt bit is set.
   function automatic logic [PC_W-1:0] first_pc(input logic [NUM_HARTS-1:0]      h,
                                                input logic [NUM_HARTS*PC_W-1:0] pcs);
      logic [PC_W-1:0] r;
      r = '0;
      for (int i = NUM_HARTS - 1; i >= 0; i--) begin
         if (h[i]) r = pcs[i*PC_W +: PC_W];
      end
      return r;
   endfunction

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_nxt;
   end

   // Next-state logic with completion/timeout decode; completion beats timeout.
   always_comb begin
      state_nxt = state_q;
      halt_m    = halt_mask | hart_halt;
      start_acc = start && ((state_q == S_IDLE) || (state_q == S_DONE));
      complete  = 1'b0;
      limit_hit = 1'b0;
      if (state_q == S_RUN) begin
         if (HALT_MODE == 0) complete = |halt_m;
         else                complete = &halt_m;
         limit_hit = (limit_q != '0) && (cycle_count >= limit_q) && !complete;
      end
      case (state_q)
         S_IDLE:  if (start_acc) state_nxt = S_RESET;
         S_RESET: if (hold_cnt == HOLD_LAST) state_nxt = S_RUN;
         S_RUN:   if (complete || limit_hit) state_nxt = S_DONE;
         S_DONE:  if (start_acc) state_nxt = S_RESET;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Registered control outputs; core stays out of reset in DONE for inspection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         core_resetn <= 1'b0;
         running     <= 1'b0;
      end else begin
         core_resetn <= (state_nxt == S_RUN) || (state_nxt == S_DONE);
         running     <= (state_nxt == S_RUN);
      end
   end

   // Run datapath: clear on accepted start, accumulate and capture during RUN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         limit_q     <= '0;
         hold_cnt    <= '0;
         cycle_count <= '0;
         halt_mask   <= '0;
         done        <= 1'b0;
         timeout     <= 1'b0;
         halt_cycle  <= '0;
         halt_pc     <= '0;
      end else if (start_acc) begin
         limit_q     <= max_cycles;
         hold_cnt    <= '0;
         cycle_count <= '0;
         halt_mask   <= '0;
         done        <= 1'b0;
         timeout     <= 1'b0;
         halt_cycle  <= '0;
         halt_pc     <= '0;
      end else if (state_q == S_RESET) begin
         hold_cnt <= hold_cnt + 32'd1;
      end else if (state_q == S_RUN) begin
         halt_mask   <= halt_m;
         cycle_count <= sat_inc(cycle_count);
         if ((halt_mask == '0) && (hart_halt != '0))
            halt_pc <= first_pc(hart_halt, hart_pc);
         if (complete) begin
            done       <= 1'b1;
            halt_cycle <= cycle_count;
         end else if (limit_hit) begin
            done       <= 1'b1;
            timeout    <= 1'b1;
            halt_cycle <= cycle_count;
         end
      end
   end

endmodule

// File: doc/run_ctrl_monitor.md
Name: run_ctrl_monitor

Overview:
- Synthesizable run controller and completion monitor for multi-hart AD48 SoC simulation and FPGA bring-up.
- Sequences core reset and counts run cycles.
- Aggregates per-hart halt signals under a selectable ANY/ALL policy and enforces a cycle-limit timeout.
- Captures halt cycle and PC for reporting.
- Sits between bench/host control and the SoC's core reset and halt/PC taps.

Parameters:
NUM_HARTS, 1, number of monitored harts
CNT_W, 32, width of cycle counter and limit
PC_W, 48, width of each hart PC
RESET_HOLD, 4, cycles core_resetn is held low after start; 0 is treated as 1
HALT_MODE, 0, 0 = complete when any hart halts, 1 = complete when all harts have halted (sticky)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
start  input  1  single-cycle request to begin or restart a run
max_cycles  input  CNT_W  cycle limit, latched on accepted start; 0 = unlimited
hart_halt  input  NUM_HARTS  per-hart halt level
hart_pc  input  NUM_HARTS*PC_W  per-hart PC, hart i at bits [i*PC_W +: PC_W]
core_resetn  output  1  active-low reset driven to SoC core(s)
running  output  1  high in RUN
done  output  1  run finished, by halt or timeout
timeout  output  1  run ended by cycle limit
cycle_count  output  CNT_W  RUN cycles elapsed
halt_mask  output  NUM_HARTS  sticky record of harts seen halted in RUN
halt_cycle  output  CNT_W  cycle_count value at completion
halt_pc  output  PC_W  PC of first-halting hart
state  output  2  IDLE=0, RESET=1, RUN=2, DONE=3

Behaviour:
- Reset (rst high, async): state=IDLE; core_resetn=0. running, done, timeout, cycle_count, halt_mask, halt_cycle, halt_pc all 0. Latched limit is 0.
- All outputs are registered. running = (state==RUN).
- IDLE:
  - core_resetn=0.
  - start → RESET next cycle. Latch max_cycles. Clear cycle_count, halt_mask, done, timeout, halt_cycle, halt_pc. Clear hold counter.
- RESET:
  - core_resetn=0 for exactly max(RESET_HOLD,1) cycles, counted from the cycle state==RESET.
  - Then → RUN; core_resetn=1 from the first RUN cycle.
  - start is ignored.
- RUN, each cycle:
  - halt_mask <= halt_mask | hart_halt.
  - cycle_count <= cycle_count+1, saturating at all-ones.
  - First halt: in the first cycle where halt_mask==0 and hart_halt!=0, halt_pc <= PC of the lowest-index set hart. halt_pc does not update again this run.
  - Completion term m = halt_mask|hart_halt. Completion when (HALT_MODE==0 and m!=0) or (HALT_MODE==1 and m all-ones).
  - On completion: done<=1, halt_cycle<=current cycle_count (pre-increment), → DONE. cycle_count still increments in that cycle.
  - Timeout when latched limit !=0 and cycle_count >= limit and no completion this cycle: timeout<=1, done<=1, halt_cycle<=cycle_count, → DONE.
  - Completion and timeout in the same cycle: completion wins, timeout stays 0.
  - start is ignored.
- DONE:
  - core_resetn stays 1 so core state remains inspectable.
  - All status outputs held.
  - start → RESET with the same clearing as from IDLE; core_resetn drops to 0 next cycle.
- hart_halt outside RUN is ignored.
- rst mid-run: immediate return to reset values; core_resetn=0 asynchronously.

Test Plan:
- NUM_HARTS=1, RESET_HOLD=4, max_cycles=0. Pulse start at cycle 0; raise hart_halt in RUN cycle 10 with hart_pc=0x123 → core_resetn low cycles 1–4, high at 5; done=1, timeout=0, halt_cycle=10, halt_pc=0x123, state=3.
- max_cycles=20, hart_halt never set → timeout=1, done=1, halt_cycle=20, halt_mask=0. cycle_count=21 one cycle after DONE entry, then held.
- NUM_HARTS=4, HALT_MODE=1. Halt harts 2, 0, then (1,3) at RUN cycles 5, 8, 12, with hart 2 PC=0xA0 → done at halt_cycle=12, halt_mask=4'hF, halt_pc=0xA0. Same stimulus with HALT_MODE=0 → done at 5.
- Simultaneous: max_cycles=15, hart_halt rises in RUN cycle 15 → done=1, timeout=0, halt_cycle=15.
- Harts 1 and 3 halt together in the same first cycle, PCs 0x10/0x30 → halt_pc=0x10.
- Restart and abort:
  - start in DONE → RESET; all status cleared; second run completes normally.
  - rst asserted mid-RUN → state=0, core_resetn=0 in the same timestep; all counters 0.
  - start during RUN → no effect.
